// File: rtl/game_flow_ctrl.sv
// Gomoku game-flow controller: avatar selection for 2..4 players, turn rotation
// with per-turn tick timeout, win/draw detection hand-off, rematch and restart.
module game_flow_ctrl #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_AVATARS = 8,
    parameter int TURN_TICKS  = 30,
    localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    localparam int AW = (NUM_AVATARS > 2) ? $clog2(NUM_AVATARS) : 1,
    localparam int TW = (TURN_TICKS > 0) ? $clog2(TURN_TICKS + 1) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic                      confirm,
    input  logic [AW-1:0]             avatar_sel,
    input  logic                      move_valid,
    input  logic                      win_detect,
    input  logic                      board_full,
    input  logic                      rematch,
    input  logic                      restart,
    output logic [1:0]                state,
    output logic [PW-1:0]             cur_player,
    output logic [NUM_PLAYERS*AW-1:0] avatars,
    output logic [PW-1:0]             winner,
    output logic [TW-1:0]             time_left,
    output logic                      reject,
    output logic                      timeout
);

    typedef enum logic [1:0] {
        ST_SELECT = 2'd0,
        ST_PLAY   = 2'd1,
        ST_WIN    = 2'd2,
        ST_DRAW   = 2'd3
    } state_t;

    localparam logic [PW-1:0] LAST_P  = PW'(NUM_PLAYERS - 1);
    localparam logic [TW-1:0] TT_L    = TW'(TURN_TICKS);
    localparam logic [AW:0]   NA_L    = (AW + 1)'(NUM_AVATARS);
    localparam int            TAKEN_W = 1 << AW;

    state_t                state_reg, state_next;
    logic [PW-1:0]         cur_player_reg, cur_player_next;
    logic [AW-1:0]         avatar_reg [NUM_PLAYERS];
    logic [AW-1:0]         avatar_next [NUM_PLAYERS];
    logic [TAKEN_W-1:0]    taken_reg, taken_next;
    logic [PW-1:0]         winner_reg, winner_next;
    logic [TW-1:0]         time_left_reg, time_left_next;
    logic                  reject_reg, reject_next;
    logic                  timeout_reg, timeout_next;
    logic                  avatar_ok;

    function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    // taken is sized to the full index space so an out-of-range offer still indexes safely
    assign avatar_ok = ({1'b0, avatar_sel} < NA_L) && !taken_reg[avatar_sel];

    always_comb begin
        state_next      = state_reg;
        cur_player_next = cur_player_reg;
        avatar_next     = avatar_reg;
        taken_next      = taken_reg;
        winner_next     = winner_reg;
        time_left_next  = time_left_reg;
        reject_next     = 1'b0;
        timeout_next    = 1'b0;

        if (restart) begin
            state_next      = ST_SELECT;
            cur_player_next = '0;
            taken_next      = '0;
            winner_next     = '0;
            time_left_next  = TT_L;
            for (int i = 0; i < NUM_PLAYERS; i++) avatar_next[i] = '0;
        end else begin
            case (state_reg)
                ST_SELECT: begin
                    if (confirm) begin
                        if (avatar_ok) begin
                            avatar_next[cur_player_reg] = avatar_sel;
                            taken_next[avatar_sel]      = 1'b1;
                            if (cur_player_reg == LAST_P) begin
                                state_next      = ST_PLAY;
                                cur_player_next = '0;
                                time_left_next  = TT_L;
                            end else begin
                                cur_player_next = cur_player_reg + 1'b1;
                            end
                        end else begin
                            reject_next = 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    // a move always beats a coincident tick
                    if (move_valid && win_detect) begin
                        state_next  = ST_WIN;
                        winner_next = cur_player_reg;
                    end else if (move_valid && board_full) begin
                        state_next = ST_DRAW;
                    end else if (move_valid) begin
                        cur_player_next = next_player(cur_player_reg);
                        time_left_next  = TT_L;
                    end else if (tick && TURN_TICKS != 0) begin
                        if (time_left_reg == TW'(1)) begin
                            timeout_next    = 1'b1;
                            cur_player_next = next_player(cur_player_reg);
                            time_left_next  = TT_L;
                        end else begin
                            time_left_next = time_left_reg - 1'b1;
                        end
                    end
                end
                ST_WIN: begin
                    if (rematch) begin
                        state_next      = ST_PLAY;
                        cur_player_next = next_player(winner_reg);
                        time_left_next  = TT_L;
                    end
                end
                default: begin
                    if (rematch) begin
                        state_next      = ST_PLAY;
                        cur_player_next = '0;
                        time_left_next  = TT_L;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_SELECT;
            cur_player_reg <= '0;
            taken_reg      <= '0;
            winner_reg     <= '0;
            time_left_reg  <= TT_L;
            reject_reg     <= 1'b0;
            timeout_reg    <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) avatar_reg[i] <= '0;
        end else begin
            state_reg      <= state_next;
            cur_player_reg <= cur_player_next;
            avatar_reg     <= avatar_next;
            taken_reg      <= taken_next;
            winner_reg     <= winner_next;
            time_left_reg  <= time_left_next;
            reject_reg     <= reject_next;
            timeout_reg    <= timeout_next;
        end
    end

    assign state      = state_reg;
    assign cur_player = cur_player_reg;
    assign winner     = winner_reg;
    assign time_left  = time_left_reg;
    assign reject     = reject_reg;
    assign timeout    = timeout_reg;

    generate
        for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_pack
            assign avatars[gi*AW +: AW] = avatar_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: 3 players, 8 avatars, 3-tick turns.
// Directed test-plan sequences followed by randomized play against a reference model.
module tb_game_flow_ctrl;

    localparam int NP = 3;
    localparam int NA = 8;
    localparam int TT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, confirm = 1'b0, move_valid = 1'b0, win_detect = 1'b0;
    logic       board_full = 1'b0, rematch = 1'b0, restart = 1'b0;
    logic [2:0] avatar_sel = 3'd0;
    logic [1:0] state;
    logic [1:0] cur_player;
    logic [8:0] avatars;
    logic [1:0] winner;
    logic [1:0] time_left;
    logic       reject, timeout;

    game_flow_ctrl #(.NUM_PLAYERS(NP), .NUM_AVATARS(NA), .TURN_TICKS(TT)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .confirm(confirm), .avatar_sel(avatar_sel),
        .move_valid(move_valid), .win_detect(win_detect), .board_full(board_full),
        .rematch(rematch), .restart(restart), .state(state), .cur_player(cur_player),
        .avatars(avatars), .winner(winner), .time_left(time_left), .reject(reject),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st, cur, av, win, tl, rej, to;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    // reference model: game-level quantities only (0=select,1=play,2=win,3=draw)
    int m_st, m_cur, m_win, m_tl, m_rej, m_to;
    int m_av[NP];

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = 0; m_cur = 0; m_win = 0; m_tl = TT; m_rej = 0; m_to = 0;
        for (int i = 0; i < NP; i++) m_av[i] = 0;
    endfunction

    function automatic int packed_av();
        int v = 0;
        for (int i = 0; i < NP; i++) v += m_av[i] << (3 * i);
        return v;
    endfunction

    function automatic void model_step(input bit cf, input int as, input bit mv, input bit wd,
                                       input bit bf, input bit tk, input bit rm, input bit rs);
        bit dup;
        m_rej = 0;
        m_to  = 0;
        if (rs) begin
            model_reset();
        end else if (m_st == 0) begin
            if (cf) begin
                // an avatar is taken if any earlier player already chose it
                dup = (as >= NA);
                for (int j = 0; j < m_cur; j++) if (m_av[j] == as) dup = 1;
                if (dup) m_rej = 1;
                else begin
                    m_av[m_cur] = as;
                    m_cur++;
                    if (m_cur == NP) begin m_st = 1; m_cur = 0; m_tl = TT; end
                end
            end
        end else if (m_st == 1) begin
            if (mv && wd) begin m_st = 2; m_win = m_cur; end
            else if (mv && bf) m_st = 3;
            else if (mv) begin m_cur = (m_cur + 1) % NP; m_tl = TT; end
            else if (tk && TT > 0) begin
                if (m_tl == 1) begin m_to = 1; m_cur = (m_cur + 1) % NP; m_tl = TT; end
                else m_tl--;
            end
        end else if (rm) begin
            m_cur = (m_st == 2) ? (m_win + 1) % NP : 0;
            m_st  = 1;
            m_tl  = TT;
        end
    endfunction

    task automatic step(input bit cf, input int as, input bit mv, input bit wd,
                        input bit bf, input bit tk, input bit rm, input bit rs);
        exp_t e;
        @(negedge clk);
        confirm = cf; avatar_sel = 3'(as); move_valid = mv; win_detect = wd;
        board_full = bf; tick = tk; rematch = rm; restart = rs;
        model_step(cf, as, mv, wd, bf, tk, rm, rs);
        e = '{m_st, m_cur, packed_av(), m_win, m_tl, m_rej, m_to};
        q.push_back(e);
    endtask

    task automatic zero_inputs();
        confirm = 0; avatar_sel = 0; move_valid = 0; win_detect = 0;
        board_full = 0; tick = 0; rematch = 0; restart = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_cur"}, int'(cur_player), 0);
        chk({tag, "_avatars"}, int'(avatars), 0);
        chk({tag, "_winner"}, int'(winner), 0);
        chk({tag, "_time_left"}, int'(time_left), TT);
        chk({tag, "_reject"}, int'(reject), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
    endtask

    // asserts rst_n between edges and checks outputs before any further clock edge
    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        zero_inputs();
        rst_n = 1'b0;
        #1;
        check_reset(tag);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // monitor: outputs are presented every cycle; compare one expected snapshot per cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_txn++;
                chk("state", int'(state), e.st);
                chk("cur_player", int'(cur_player), e.cur);
                chk("avatars", int'(avatars), e.av);
                chk("winner", int'(winner), e.win);
                chk("time_left", int'(time_left), e.tl);
                chk("reject", int'(reject), e.rej);
                chk("timeout", int'(timeout), e.to);
                $display("txn %0d: st=%0d cur=%0d av=%03h win=%0d tl=%0d rej=%0d to=%0d",
                         n_txn, state, cur_player, avatars, winner, time_left, reject, timeout);
            end
        end
    end

    initial begin
        bit cf, mv, wd, bf, tk, rm, rs;
        int as;
        model_reset();
        @(posedge clk);
        #2;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        // selection with a duplicate offer
        step(1, 2, 0, 0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0, 0);
        step(1, 5, 0, 0, 0, 0, 0, 0);
        step(1, 7, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("sel_avatars", int'(avatars), (7 << 6) | (5 << 3) | 2);
        chk("sel_state", int'(state), 1);
        chk("sel_cur", int'(cur_player), 0);

        // timeout forfeit, then rotation, win, rematch, draw precedence
        repeat (3) step(0, 0, 0, 0, 0, 1, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 1, 0, 0);
        @(posedge clk);
        #2;
        chk("win_state", int'(state), 2);
        chk("win_winner", int'(winner), 1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0, 0, 1);
        @(posedge clk);
        #2;
        chk("restart_state", int'(state), 0);
        chk("restart_avatars", int'(avatars), 0);

        // reselect, burn one tick, then async reset mid-turn
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        async_reset("midturn");

        for (int c = 0; c < 4000; c++) begin
            if (c % 997 == 996) async_reset("rand_rst");
            cf = ($urandom_range(1) == 1);
            as = $urandom_range(NA - 1);
            mv = ($urandom_range(3) == 0);
            wd = ($urandom_range(7) == 0);
            bf = ($urandom_range(7) == 0);
            tk = ($urandom_range(1) == 1);
            rm = ($urandom_range(5) == 0);
            rs = ($urandom_range(99) == 0);
            step(cf, as, mv, wd, bf, tk, rm, rs);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
